// File: rtl/uart_tx.sv
// UART transmit serializer.
// Pops one word from the TX FIFO when enabled and the FIFO is non-empty, then
// shifts out start bit, data bits LSB-first, optional parity bit and stop
// bit(s), each held for ClksPerBit clock cycles. The serial line comes
// straight from a flop so it never glitches.
module uart_tx #(
  parameter int ClksPerBit = 868,
  parameter int DataBits   = 8,
  parameter int ParityMode = 0,
  parameter int StopBits   = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tx_en_i,
  input  logic                fifo_empty_i,
  input  logic [DataBits-1:0] fifo_rdata_i,
  output logic                fifo_rd_en_o,
  output logic                tx_o,
  output logic                busy_o
);

  localparam int CntW = $clog2(ClksPerBit);
  localparam int BitW = $clog2(DataBits);
  localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DataBits - 1);
  // Index of the final stop bit within the stop phase (0 for one, 1 for two)
  localparam logic LastStop = (StopBits == 2);

  // Parameter sanity checks at elaboration time
  if (ClksPerBit < 2) begin : g_chk_cpb
    $error("uart_tx: ClksPerBit must be at least 2");
  end
  if (DataBits < 5 || DataBits > 8) begin : g_chk_db
    $error("uart_tx: DataBits must be in 5..8");
  end
  if (ParityMode < 0 || ParityMode > 2) begin : g_chk_pm
    $error("uart_tx: ParityMode must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (StopBits != 1 && StopBits != 2) begin : g_chk_sb
    $error("uart_tx: StopBits must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Parity bit for one data word: even parity is the XOR of the data,
  // odd parity is its inverse.
  function automatic logic frame_parity(input logic [DataBits-1:0] data);
    logic x;
    x = ^data;
    return (ParityMode == 1) ? ~x : x;
  endfunction

  state_t              r_state;
  logic [CntW-1:0]     r_baud;
  logic [BitW-1:0]     r_bit;
  logic                r_stop;
  logic [DataBits-1:0] r_shift;
  logic                r_parity;
  logic                r_tx;
  logic                r_busy;

  logic w_pop;
  logic w_bit_end;

  // Pop only from IDLE while enabled and the FIFO has data; held off during
  // reset so no word is consumed while the state machine cannot accept it.
  assign w_pop     = rst_ni && (r_state == S_IDLE) && tx_en_i && !fifo_empty_i;
  assign w_bit_end = (r_baud == LastCnt);

  assign fifo_rd_en_o = w_pop;
  assign tx_o         = r_tx;
  assign busy_o       = r_busy;

  // Frame sequencer: state, baud/bit/stop counters, shift register and the
  // registered line and busy outputs. The line value for each state is
  // loaded on the transition into that state so tx_o stays a pure flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_stop   <= 1'b0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (w_pop) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end

        // FIFO data is valid one cycle after the pop, so capture it here.
        S_LOAD: begin
          r_shift  <= fifo_rdata_i;
          r_parity <= frame_parity(fifo_rdata_i);
          r_baud   <= '0;
          r_bit    <= '0;
          r_stop   <= 1'b0;
          r_tx     <= 1'b0;
          r_state  <= S_START;
        end

        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        // Current bit is always shift[0]; the next one is shift[1] before
        // the shift takes effect.
        S_DATA: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit == LastBit) begin
              r_bit <= '0;
              if (ParityMode != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        // Each stop bit is a full bit period; the baud counter restarts
        // between them.
        S_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_stop == LastStop) begin
              r_stop  <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_stop <= r_stop + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
